// File: rtl/demux_pkg.sv
// Shared widths, scan-state type and wrap helper for the 1x5 registered demux.
package demux_pkg;

  localparam int unsigned DEMUX_W  = 5;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned LAST_IDX = 4;

  typedef enum logic [SEL_W-1:0] {
    Idx0 = 3'd0,
    Idx1 = 3'd1,
    Idx2 = 3'd2,
    Idx3 = 3'd3,
    Idx4 = 3'd4
  } scan_state_e;

  function automatic scan_state_e scan_next(input scan_state_e cur);
    unique case (cur)
      Idx0:    scan_next = Idx1;
      Idx1:    scan_next = Idx2;
      Idx2:    scan_next = Idx3;
      Idx3:    scan_next = Idx4;
      default: scan_next = Idx0;
    endcase
  endfunction

endpackage

// File: rtl/demux_scan_cnt.sv
// Auto-mode scan index: advances on each auto write, wraps 4 -> 0, pulses frame after idx 4.
module demux_scan_cnt
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             auto_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             frame_o
);

  scan_state_e state_q;
  logic        frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Idx0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      // Leaving auto mode parks the scan so the next auto scan starts at destination 0.
      if (clr_i || !auto_i) begin
        state_q <= Idx0;
      end else if (en_i) begin
        frame_q <= (state_q == Idx4);
        state_q <= scan_next(state_q);
      end
    end
  end

  assign idx_o   = state_q;
  assign frame_o = frame_q;

endmodule

// File: rtl/demux_1x5_reg.sv
// Registered 1-to-5 serial demux with manual select or auto scan.
// Optional out-of-range select detect enabled by defining DEMUX_SEL_ERR_EN.
module demux_1x5_reg
  import demux_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               d,
  input  logic               en,
  input  logic [SEL_W-1:0]   s,
  input  logic               auto,
  input  logic               clr,
  output logic [DEMUX_W-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               frame,
  output logic               sel_err
);

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(LAST_IDX);

  logic [DEMUX_W-1:0] y_d, y_q;
  logic [SEL_W-1:0]   idx_cur;

  demux_scan_cnt u_scan_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .auto_i  (auto),
    .clr_i   (clr),
    .idx_o   (idx_cur),
    .frame_o (frame)
  );

  always_comb begin
    y_d = y_q;
    if (clr) begin
      y_d = '0;
    end else if (en) begin
      if (auto) begin
        y_d[idx_cur] = d;
      end else if (s <= LastSel) begin
        y_d[s] = d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

`ifdef DEMUX_SEL_ERR_EN
  logic sel_err_d, sel_err_q;

  assign sel_err_d = !clr && en && !auto && (s > LastSel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

  assign y   = y_q;
  assign idx = idx_cur;

endmodule

// File: tb/tb_demux_1x5_reg.sv
// Self-checking bench for demux_1x5_reg: directed scenarios plus randomized traffic vs. a model.
module tb_demux_1x5_reg;

  logic       clk;
  logic       rst;
  logic       d;
  logic       en;
  logic [2:0] s;
  logic       auto;
  logic       clr;
  logic [4:0] y;
  logic [2:0] idx;
  logic       frame;
  logic       sel_err;

  int n_checks;
  int n_fail;

`ifdef DEMUX_SEL_ERR_EN
  localparam bit SelEn = 1'b1;
`else
  localparam bit SelEn = 1'b0;
`endif

  // Reference model state
  logic [4:0] y_m;
  int         idx_m;
  bit         frame_m;
  bit         se_m;

  demux_1x5_reg dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .en      (en),
    .s       (s),
    .auto    (auto),
    .clr     (clr),
    .y       (y),
    .idx     (idx),
    .frame   (frame),
    .sel_err (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    y_m     = '0;
    idx_m   = 0;
    frame_m = 1'b0;
    se_m    = 1'b0;
  endtask

  // Next state of the model from the inputs sampled at this edge.
  task automatic model_edge();
    frame_m = 1'b0;
    se_m    = 1'b0;
    if (clr) begin
      y_m   = '0;
      idx_m = 0;
    end else if (auto) begin
      if (en) begin
        y_m[idx_m] = d;
        frame_m    = (idx_m == 4);
        idx_m      = (idx_m + 1) % 5;
      end
    end else begin
      if (en) begin
        if (int'(s) < 5) y_m[s] = d;
        else se_m = SelEn;
      end
      idx_m = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".y"}, y, y_m);
    chk({tag, ".idx"}, {2'b00, idx}, 5'(idx_m));
    chk({tag, ".frame"}, {4'b0, frame}, {4'b0, frame_m});
    chk({tag, ".sel_err"}, {4'b0, sel_err}, {4'b0, se_m});
  endtask

  task automatic step(input logic d_v, input logic en_v, input logic [2:0] s_v,
                      input logic auto_v, input logic clr_v, input string tag);
    d    = d_v;
    en   = en_v;
    s    = s_v;
    auto = auto_v;
    clr  = clr_v;
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  // Pulse rst between edges; called at posedge+1.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_model(tag);
    #2 rst = 1'b0;
  endtask

  logic [4:0] ex;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    d    = 1'b0;
    en   = 1'b0;
    s    = 3'd0;
    auto = 1'b0;
    clr  = 1'b0;
    model_reset();
    #12;
    compare_model("reset");
    chk("reset.y_lit", y, 5'b00000);
    rst = 1'b0;

    // Manual routing walk
    ex = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 3'(i), 1'b0, 1'b0, "manual");
      chk("manual.y_lit", y, ex);
      ex = {ex[3:0], 1'b1};
    end

    // Build 10101, then out-of-range select
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, "mk10101");
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, "mk10101");
    chk("mk10101.y_lit", y, 5'b10101);
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, "oor");
    chk("oor.y_lit", y, 5'b10101);
    chk("oor.sel_err_lit", {4'b0, sel_err}, {4'b0, SelEn});
    step(1'b0, 1'b0, 3'd7, 1'b0, 1'b0, "oor_idle");
    chk("oor_idle.sel_err_lit", {4'b0, sel_err}, 5'b0);

    // Auto frame d=1,0,1,0,1
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, "clr");
    for (int i = 0; i < 5; i++) begin
      step(1'((i + 1) % 2), 1'b1, 3'd6, 1'b1, 1'b0, "auto");
      chk("auto.idx_lit", {2'b00, idx}, 5'((i + 1) % 5));
      chk("auto.frame_lit", {4'b0, frame}, {4'b0, (i == 4)});
    end
    chk("auto.y_lit", y, 5'b10101);
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, "auto_after");
    chk("auto_after.frame_lit", {4'b0, frame}, 5'b0);

    // Auto gaps: en 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'((i + 1) % 2), 3'd0, 1'b1, 1'b0, "gaps");
      chk("gaps.idx_lit", {2'b00, idx}, 5'((i / 2) + 1));
    end

    // Mid-scan abort
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, "abort_clr");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, "abort_pre");
    async_reset("abort_rst");
    chk("abort.y_lit", y, 5'b00000);
    chk("abort.idx_lit", {2'b00, idx}, 5'b0);
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, "abort_post");
    chk("abort_post.y_lit", y, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, "abort_tail");
      chk("abort_tail.frame_lit", {4'b0, frame}, 5'b0);
    end

    // Clear priority at idx=4
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, "clrpri");
    chk("clrpri.y_lit", y, 5'b00000);
    chk("clrpri.idx_lit", {2'b00, idx}, 5'b0);
    chk("clrpri.frame_lit", {4'b0, frame}, 5'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      automatic int  r    = $urandom_range(0, 99);
      automatic bit  a_v  = auto;
      if (r < 2) async_reset("rand_rst");
      if ($urandom_range(0, 9) == 0) a_v = ~a_v;
      step(1'($urandom), ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), a_v,
           ($urandom_range(0, 29) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x5_reg.md
DEMUX_1X5_REG -- requirements
Module: demux_1x5_reg

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 d  input  1  serial data bit to be routed.
REQ-005 en  input  1  sample strobe; d is written only when en=1.
REQ-006 s  input  3  manual destination select, valid range 0..4.
REQ-007 auto  input  1  1 = internal scan index selects destination; 0 = s selects.
REQ-008 clr  input  1  synchronous clear of y and scan index.
REQ-009 y  output  5  registered destination bits; y[k] is destination k.
REQ-010 idx  output  3  current scan index, range 0..4.
REQ-011 frame  output  1  one-cycle pulse when a 5-bit auto frame completes.
REQ-012 sel_err  output  1  one-cycle pulse on an out-of-range manual select (see Configuration).

Function
REQ-013 Latency SHALL be one cycle: d sampled at edge N appears on y at edge N, visible in cycle N+1.
REQ-014 Manual mode (auto=0, en=1, s<=4): y[s] <= d; other y bits SHALL hold.
REQ-015 Manual mode (auto=0, en=1, s>=5): no y bit SHALL change.
REQ-016 Auto mode (auto=1, en=1): y[idx] <= d, then idx SHALL increment, wrapping 4 -> 0.
REQ-017 Scan states: IDX0..IDX4; advance only on auto&en; hold on en=0.
REQ-018 frame SHALL pulse high for exactly the cycle after a write at idx=4 in auto mode; otherwise 0.
REQ-019 When auto=0, idx SHALL be forced to 0 at the next edge, so a new auto scan always starts at destination 0.
REQ-020 When auto rises in the same cycle as en=1, the write SHALL go to idx=0.
REQ-021 In auto mode, s SHALL be ignored and sel_err SHALL NOT assert.
REQ-022 clr=1 SHALL clear y to 5'b00000 and idx to 0 at the next edge, and suppress frame and sel_err; clr SHALL take priority over en.
REQ-023 en=0 SHALL leave all state unchanged, and frame and sel_err SHALL be 0.

Reset
REQ-024 rst=1 SHALL immediately force y=5'b00000, idx=0, frame=0 and sel_err=0, independent of clk.
REQ-025 Reset asserted mid-scan SHALL abandon the partial frame, with no frame pulse.
REQ-026 After reset release, the first auto write SHALL target destination 0.

Configuration
REQ-027 The macro DEMUX_SEL_ERR_EN SHALL control the out-of-range detect.
- Defined: sel_err pulses one cycle after a manual en=1 with s>=5.
- Undefined: sel_err is tied to 0 and no detect logic is built.
- In both builds, REQ-015 holds.

Structure
REQ-028 Package demux_pkg SHALL hold DEMUX_W=5, SEL_W=3, LAST_IDX=4 and the scan-state typedef.
REQ-029 The scan counter (idx, wrap and frame generation) SHALL be a sub-module named demux_scan_cnt.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Manual routing: auto=0, en=1, d=1, s=0..4 in turn, from reset -> y steps 00001, 00011, 00111, 01111, 11111.
REQ-032 Out-of-range select: y=10101, manual s=7, d=0, en=1 -> y stays 10101; sel_err=1 for one cycle only when DEMUX_SEL_ERR_EN is defined.
REQ-033 Auto frame: auto=1, en=1, serial d=1,0,1,0,1 -> y=10101, idx 0->1->2->3->4->0, frame pulses once after the fifth bit.
REQ-034 Auto gaps: auto=1 with en toggling 1,0,1,0 -> idx advances only on en=1 cycles and no y change occurs on en=0.
REQ-035 Mid-scan abort: after 3 auto bits, assert rst asynchronously (between edges) -> y=00000 and idx=0 immediately; after release, the next bit lands in y[0] and there is no frame pulse.
REQ-036 Clear priority: clr=1 and en=1 with auto=1 and idx=4 -> y=00000, idx=0, frame=0.
